wb_uart_rx: RTL

//  Wishbone B4 classic slave UART receiver: the receive half of the SoC console link, inbound from uart_rx.

---
 rtl/wb_uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/wb_uart_rx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_uart_pkg.sv
// Shared UART register map, STATUS bit positions and receive FSM encoding.
// Constants only: no latency, no flow control.
package wb_uart_pkg;

  localparam logic [2:0] REG_RXDATA = 3'h0;
  localparam logic [2:0] REG_STATUS = 3'h4;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVR   = 1;
  localparam int STAT_FERR  = 2;
  localparam int STAT_COUNT = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  function automatic logic [31:0] status_word(input logic [4:0] count, input logic ferr,
                                              input logic ovr, input logic valid);
    logic [31:0] w;
    w = '0;
    w[STAT_COUNT +: 5] = count;
    w[STAT_FERR]       = ferr;
    w[STAT_OVR]        = ovr;
    w[STAT_VALID]      = valid;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO, first-word-fall-through; one-cycle write-to-read latency.
// Push into a full FIFO is ignored unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone classic UART receiver (8N1, 16x oversampling) with byte FIFO; ack one cycle after request.
// Bytes arriving while the FIFO is full are dropped and flagged as overrun; the bus never stalls.
module wb_uart_rx
  import wb_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 24000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_AW     = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int DIV = CLK_FREQ_HZ / (16 * BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic rx_s1, rx_s2, armed;
  logic [1:0] warm;
  logic start_edge;

  // armed only follows the line once the synchroniser holds real samples,
  // so a line held low across reset release is never taken as a start edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      warm  <= {warm[0], 1'b1};
      armed <= warm[1] & rx_s2;
    end
  end
  assign start_edge = armed & ~rx_s2;

  rx_state_t state_q, state_d;
  logic [TW-1:0] tcnt;
  logic tick;
  logic [3:0] sub;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic samp_bit, byte_ok, ferr_set, clr_sub;

  assign tick = (state_q != RX_IDLE) && (tcnt == TW'(DIV - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                          tcnt <= '0;
    else if (state_q == RX_IDLE || tick)  tcnt <= '0;
    else                                  tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (start_edge) state_d = RX_START;
      RX_START: if (tick && sub == 4'd7) state_d = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && sub == 4'd15 && bitcnt == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick && sub == 4'd15) state_d = rx_s2 ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_s2) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    samp_bit = (state_q == RX_DATA) && tick && (sub == 4'd15);
    byte_ok  = (state_q == RX_STOP) && tick && (sub == 4'd15) && rx_s2;
    ferr_set = (state_q == RX_STOP) && tick && (sub == 4'd15) && !rx_s2;
    clr_sub  = (state_q == RX_IDLE) || ((state_q == RX_START) && tick && (sub == 4'd7));
  end

  // sub wraps 15->0 on its own, so DATA bits and STOP stay 16 ticks apart.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sub    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (clr_sub)   sub <= '0;
      else if (tick) sub <= sub + 1'b1;
      if (state_q != RX_DATA) bitcnt <= '0;
      else if (samp_bit)      bitcnt <= bitcnt + 1'b1;
      if (samp_bit) shreg <= {rx_s2, shreg[7:1]};
    end
  end

  logic [7:0]       fifo_dout;
  logic             fifo_empty, fifo_full, fifo_pop;
  logic [FIFO_AW:0] fifo_count;

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (byte_ok),
    .din    (shreg),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  logic req, is_status, ovr, ferr, ovr_clr, ferr_clr, ovr_set;
  logic [31:0] rd_data;
  logic unused;

  assign unused    = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:3], wb_dat_i[0]};
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign is_status = (wb_adr_i[2] == REG_STATUS[2]);
  assign ovr_set   = byte_ok & fifo_full & ~fifo_pop;
  assign ovr_clr   = req & wb_we_i & is_status & wb_dat_i[STAT_OVR];
  assign ferr_clr  = req & wb_we_i & is_status & wb_dat_i[STAT_FERR];

  always_comb begin
    rd_data = '0;
    if (is_status)        rd_data = status_word(5'(fifo_count), ferr, ovr, ~fifo_empty);
    else if (!fifo_empty) rd_data = {23'b0, 1'b1, fifo_dout};
  end

  // The pop decision is latched with the read data so the entry returned is the entry removed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      fifo_pop <= 1'b0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rd_data : '0;
      fifo_pop <= req & ~wb_we_i & ~is_status & ~fifo_empty;
      ovr      <= ovr_set | (ovr & ~ovr_clr);
      ferr     <= ferr_set | (ferr & ~ferr_clr);
      irq      <= ~fifo_empty | ovr | ferr;
    end
  end

endmodule
